multichannel_voltage_scaler: RTL and testbench

Parametrised, pipelined ADC-code-to-millivolt scaler for the multi-channel voltage display path. It accepts one tagged sample per cycle from the channel sequencer and computes out = floor(in × MUL × SCALE / DIV), saturated to OUT_W. It emits the result with its channel tag and keeps a per-channel bank of last value and peak-hold value. The display logic reads the bank through a registered read port.

---
 rtl/multichannel_voltage_scaler.sv | 132 +++++++++++++
 tb/tb_multichannel_voltage_scaler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_voltage_scaler.sv
// Pipelined ADC-code to millivolt scaler: out = floor(in * MUL * SCALE / DIV), saturated,
// with a per-channel bank of last and peak-hold values behind a registered read port.
module multichannel_voltage_scaler #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12,
    parameter int CH    = 13,
    parameter int CH_W  = 4,
    parameter int MUL   = 25_177,
    parameter int SCALE = 32,
    parameter int DIV   = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [OUT_W-1:0] out,
    output logic             out_sat,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [OUT_W-1:0] rd_last,
    output logic [OUT_W-1:0] rd_peak,
    input  logic             peak_clr
);

    localparam int MUL_BITS   = $clog2(MUL + 1);
    localparam int SCALE_BITS = $clog2(SCALE + 1);
    localparam int P1_W       = IN_W + MUL_BITS;
    localparam int PROD_W     = P1_W + SCALE_BITS;

    localparam logic [P1_W-1:0]   MUL_C   = P1_W'(MUL);
    localparam logic [PROD_W-1:0] SCALE_C = PROD_W'(SCALE);
    localparam logic [PROD_W-1:0] DIV_C   = PROD_W'(DIV);
    localparam logic [PROD_W-1:0] OUT_MAX = PROD_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [CH_W:0]     CH_C    = (CH_W + 1)'(CH);

    logic              s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [CH_W-1:0]   s1_ch_reg, s2_ch_reg, s3_ch_reg;
    logic [P1_W-1:0]   s1_data_reg;
    logic [PROD_W-1:0] s2_data_reg;
    logic [PROD_W-1:0] s3_data_reg;

    logic              sat_next;
    logic [OUT_W-1:0]  out_next;

    // Data path carries no reset; only the valid/tag shadow needs clearing.
    always_ff @(posedge clk) begin
        s1_data_reg <= P1_W'(in) * MUL_C;
        s2_data_reg <= PROD_W'(s1_data_reg) * SCALE_C;
        s3_data_reg <= s2_data_reg / DIV_C;
    end

    always_comb begin
        sat_next = (s3_data_reg > OUT_MAX);
        out_next = sat_next ? {OUT_W{1'b1}} : s3_data_reg[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
            s1_ch_reg    <= '0;
            s2_ch_reg    <= '0;
            s3_ch_reg    <= '0;
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out          <= '0;
            out_sat      <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            s2_valid_reg <= s1_valid_reg;
            s3_valid_reg <= s2_valid_reg;
            s1_ch_reg    <= in_ch;
            s2_ch_reg    <= s1_ch_reg;
            s3_ch_reg    <= s2_ch_reg;
            out_valid    <= s3_valid_reg;
            out_ch       <= s3_ch_reg;
            out          <= out_next;
            out_sat      <= sat_next;
        end
    end

    logic [OUT_W-1:0] last_q [CH];
    logic [OUT_W-1:0] peak_q [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_bank
            logic             hit;
            logic [OUT_W-1:0] last_reg;
            logic [OUT_W-1:0] peak_reg;

            assign hit = out_valid && (out_ch == CH_W'(gi));

            // A clear coinciding with a write loads the new value into a fresh peak.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    last_reg <= '0;
                    peak_reg <= '0;
                end else begin
                    if (hit) begin
                        last_reg <= out;
                    end
                    if (peak_clr) begin
                        peak_reg <= hit ? out : '0;
                    end else if (hit && (out > peak_reg)) begin
                        peak_reg <= out;
                    end
                end
            end

            assign last_q[gi] = last_reg;
            assign peak_q[gi] = peak_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_last <= '0;
            rd_peak <= '0;
        end else if ({1'b0, rd_ch} < CH_C) begin
            rd_last <= last_q[rd_ch];
            rd_peak <= peak_q[rd_ch];
        end else begin
            rd_last <= '0;
            rd_peak <= '0;
        end
    end

endmodule

// File: tb/tb_multichannel_voltage_scaler.sv
// Directed bench for multichannel_voltage_scaler: table of single samples plus hand-written
// streaming, peak, same-cycle read/write and mid-stream reset sequences.
module tb_multichannel_voltage_scaler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_ch;
    logic [11:0] in_data;
    logic [3:0]  rd_ch;
    logic        peak_clr;

    logic        out_valid, out_sat;
    logic [3:0]  out_ch;
    logic [11:0] out, rd_last, rd_peak;

    logic        out_valid2, out_sat2;
    logic [3:0]  out_ch2;
    logic [11:0] out2, rd_last2, rd_peak2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multichannel_voltage_scaler dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in(in_data),
        .out_valid(out_valid), .out_ch(out_ch), .out(out), .out_sat(out_sat),
        .rd_ch(rd_ch), .rd_last(rd_last), .rd_peak(rd_peak), .peak_clr(peak_clr)
    );

    multichannel_voltage_scaler #(.MUL(40_000)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in(in_data),
        .out_valid(out_valid2), .out_ch(out_ch2), .out(out2), .out_sat(out_sat2),
        .rd_ch(rd_ch), .rd_last(rd_last2), .rd_peak(rd_peak2), .peak_clr(peak_clr)
    );

    typedef struct {
        logic [3:0]  ch;
        logic [11:0] din;
        logic [11:0] e_out;
        logic        e_sat;
        logic [11:0] e_out2;
        logic        e_sat2;
    } vec_t;

    vec_t        vecs [7];
    logic [11:0] stream_exp [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives one sample, checks the 4-cycle latency, returns with the result on the output.
    task automatic send(input logic [3:0] ch, input logic [11:0] v,
                        input logic [11:0] e_out, input logic e_sat, input string name);
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = v;
        step();
        in_valid = 1'b0;
        chk({name, " valid@1"}, 32'(out_valid), 0);
        step();
        chk({name, " valid@2"}, 32'(out_valid), 0);
        step();
        chk({name, " valid@3"}, 32'(out_valid), 0);
        step();
        chk({name, " valid@4"}, 32'(out_valid), 1);
        chk({name, " out"}, 32'(out), 32'(e_out));
        chk({name, " out_ch"}, 32'(out_ch), 32'(ch));
        chk({name, " out_sat"}, 32'(out_sat), 32'(e_sat));
        $display("[TB] %s ch %0d in %0d -> out %0d sat %0d", name, ch, v, out, out_sat);
    endtask

    task automatic read_chk(input logic [3:0] ch, input logic [11:0] e_last,
                            input logic [11:0] e_peak, input string name);
        rd_ch = ch;
        step();
        chk({name, " rd_last"}, 32'(rd_last), 32'(e_last));
        chk({name, " rd_peak"}, 32'(rd_peak), 32'(e_peak));
        $display("[TB] %s rd_ch %0d -> last %0d peak %0d", name, ch, rd_last, rd_peak);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'd3, 12'd4095, 12'd3299, 1'b0, 12'd4095, 1'b1};
        vecs[1] = '{4'd3, 12'd2048, 12'd1649, 1'b0, 12'd2621, 1'b0};
        vecs[2] = '{4'd3, 12'd2,    12'd1,    1'b0, 12'd2,    1'b0};
        vecs[3] = '{4'd3, 12'd1,    12'd0,    1'b0, 12'd1,    1'b0};
        vecs[4] = '{4'd3, 12'd0,    12'd0,    1'b0, 12'd0,    1'b0};
        vecs[5] = '{4'd3, 12'd100,  12'd80,   1'b0, 12'd128,  1'b0};
        vecs[6] = '{4'd13, 12'd4095, 12'd3299, 1'b0, 12'd4095, 1'b1};
        stream_exp = '{12'd0, 12'd80, 12'd161, 12'd241, 12'd322, 12'd402, 12'd483,
                       12'd563, 12'd644, 12'd725, 12'd805, 12'd886, 12'd966};

        in_valid = 1'b0; in_ch = '0; in_data = '0; rd_ch = '0; peak_clr = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset out", 32'(out), 0);
        chk("reset out_ch", 32'(out_ch), 0);
        chk("reset out_sat", 32'(out_sat), 0);
        chk("reset rd_last", 32'(rd_last), 0);
        chk("reset rd_peak", 32'(rd_peak), 0);
        rst_n = 1'b1;

        // Single-sample table, both gain settings.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].ch, vecs[i].din, vecs[i].e_out, vecs[i].e_sat, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d sat_dut out", i), 32'(out2), 32'(vecs[i].e_out2));
            chk($sformatf("vec%0d sat_dut out_sat", i), 32'(out_sat2), 32'(vecs[i].e_sat2));
        end
        step();
        read_chk(4'd3, 12'd80, 12'd3299, "table ch3");
        read_chk(4'd13, 12'd0, 12'd0, "table ch13");

        // Streaming 13 back-to-back samples.
        do_reset();
        for (int t = 0; t < 17; t++) begin
            if (t < 13) begin
                in_valid = 1'b1;
                in_ch    = 4'(t);
                in_data  = 12'(100 * t);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (t >= 3 && t < 16) begin
                chk($sformatf("stream%0d valid", t - 3), 32'(out_valid), 1);
                chk($sformatf("stream%0d ch", t - 3), 32'(out_ch), 32'(t - 3));
                chk($sformatf("stream%0d out", t - 3), 32'(out), 32'(stream_exp[t - 3]));
                $display("[TB] stream ch %0d -> out %0d", out_ch, out);
            end else begin
                chk($sformatf("stream gap t%0d", t), 32'(out_valid), 0);
            end
        end
        for (int c = 0; c < 13; c++) begin
            read_chk(4'(c), stream_exp[c], stream_exp[c], $sformatf("stream bank%0d", c));
        end

        // Peak hold and clear coincident with a write.
        send(4'd5, 12'd1000, 12'd805, 1'b0, "peak a");
        send(4'd5, 12'd3000, 12'd2416, 1'b0, "peak b");
        send(4'd5, 12'd2000, 12'd1611, 1'b0, "peak c");
        step();
        read_chk(4'd5, 12'd1611, 12'd2416, "peak ch5");
        send(4'd5, 12'd500, 12'd402, 1'b0, "peak clr");
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        read_chk(4'd5, 12'd402, 12'd402, "after clr ch5");
        read_chk(4'd3, 12'd241, 12'd0, "after clr ch3");
        read_chk(4'd12, 12'd966, 12'd0, "after clr ch12");

        // Same-cycle write and read of ch2.
        send(4'd2, 12'd2048, 12'd1649, 1'b0, "wr ch2");
        rd_ch = 4'd2;
        step();
        chk("same-cycle rd_last", 32'(rd_last), 161);
        chk("same-cycle rd_peak", 32'(rd_peak), 0);
        step();
        chk("next-cycle rd_last", 32'(rd_last), 1649);
        chk("next-cycle rd_peak", 32'(rd_peak), 1649);
        $display("[TB] same-cycle ch2 -> last %0d peak %0d", rd_last, rd_peak);

        read_chk(4'd13, 12'd0, 12'd0, "oob 13");
        read_chk(4'd14, 12'd0, 12'd0, "oob 14");
        read_chk(4'd15, 12'd0, 12'd0, "oob 15");

        // Mid-stream reset: three samples in flight are discarded.
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_ch = 4'(k); in_data = 12'd4095;
            step();
        end
        in_ch = 4'd4;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("midreset out_valid", 32'(out_valid), 0);
        chk("midreset rd_last", 32'(rd_last), 0);
        step();
        chk("post-release valid", 32'(out_valid), 0);
        send(4'd6, 12'd2048, 12'd1649, 1'b0, "post-reset");
        step();
        chk("post-reset trailing valid", 32'(out_valid), 0);
        for (int c = 0; c < 13; c++) begin
            read_chk(4'(c), (c == 6) ? 12'd1649 : 12'd0, (c == 6) ? 12'd1649 : 12'd0,
                     $sformatf("reset bank%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
